// File: rtl/regfile_write_decoder_if.sv
// Write-port bundle between issue logic and the register-file write decoder.
// The decoder drives strobes, per-register winning port and clear/status flags.
interface regfile_write_decoder_if #(
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int NUM_PORTS = 2,
  parameter int PSEL_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
  logic [NUM_PORTS-1:0]        wr_en;
  logic [NUM_PORTS*ADDR_W-1:0] wr_addr;
  logic                        clear_req;
  logic [NUM_REGS-1:0]         we;
  logic [NUM_REGS*PSEL_W-1:0]  port_sel;
  logic                        clear_active;
  logic                        busy;
  logic                        conflict;
  logic                        addr_err;

  modport master (
    output wr_en, wr_addr, clear_req,
    input  we, port_sel, clear_active, busy, conflict, addr_err
  );

  modport slave (
    input  wr_en, wr_addr, clear_req,
    output we, port_sel, clear_active, busy, conflict, addr_err
  );
endinterface

// File: rtl/regfile_write_decoder.sv
// Registered multi-port write-enable decoder with later-port-wins priority,
// conflict/range flags and a sequential bulk-clear walk over writable registers.
module regfile_write_decoder #(
  parameter int ADDR_W      = 5,
  parameter int NUM_REGS    = 32,
  parameter int NUM_PORTS   = 2,
  parameter int ZERO_REG_RO = 1
) (
  input  logic             clk,
  input  logic             reset,
  regfile_write_decoder_if.slave bus
);
  localparam int PSEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'((ZERO_REG_RO != 0) ? 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [ADDR_W-1:0]          cnt_r, cnt_nxt_s;
  logic [NUM_REGS-1:0]        we_r, we_nxt_s;
  logic [NUM_REGS*PSEL_W-1:0] psel_r, psel_nxt_s;
  logic                       conflict_r, conflict_nxt_s;
  logic                       addr_err_r, addr_err_nxt_s;
  logic [ADDR_W-1:0]          addr_s;
  logic                       match_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // Register 0 may be hardwired to zero, so it is legal but never strobed.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return in_range(a) && !((ZERO_REG_RO != 0) && (a == '0));
  endfunction

  function automatic logic [NUM_REGS-1:0] strobe_of(input logic [ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    for (int r = 0; r < NUM_REGS; r++) begin
      v[r] = (idx == ADDR_W'(r));
    end
    return v;
  endfunction

  // Next-state, clear counter and next registered outputs
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    we_nxt_s       = '0;
    psel_nxt_s     = '0;
    conflict_nxt_s = 1'b0;
    addr_err_nxt_s = 1'b0;
    addr_s         = '0;
    match_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.clear_req) begin
          state_nxt_s = CLEAR;
          cnt_nxt_s   = FIRST_IDX;
          we_nxt_s    = strobe_of(FIRST_IDX);
        end else begin
          // Ascending port order lets the highest-index port overwrite the select.
          for (int r = 0; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              addr_s  = bus.wr_addr[p*ADDR_W +: ADDR_W];
              match_s = bus.wr_en[p] && writable(addr_s) && (addr_s == ADDR_W'(r));
              conflict_nxt_s = conflict_nxt_s | (match_s & we_nxt_s[r]);
              we_nxt_s[r]    = we_nxt_s[r] | match_s;
              psel_nxt_s[r*PSEL_W +: PSEL_W] = match_s ? PSEL_W'(p)
                                                       : psel_nxt_s[r*PSEL_W +: PSEL_W];
            end
          end
          for (int p = 0; p < NUM_PORTS; p++) begin
            addr_s         = bus.wr_addr[p*ADDR_W +: ADDR_W];
            addr_err_nxt_s = addr_err_nxt_s | (bus.wr_en[p] & ~in_range(addr_s));
          end
        end
      end
      CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + ADDR_W'(1);
          we_nxt_s  = strobe_of(cnt_r + ADDR_W'(1));
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State register, clear counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      we_r       <= '0;
      psel_r     <= '0;
      conflict_r <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      we_r       <= we_nxt_s;
      psel_r     <= psel_nxt_s;
      conflict_r <= conflict_nxt_s;
      addr_err_r <= addr_err_nxt_s;
    end
  end

  assign bus.we           = we_r;
  assign bus.port_sel     = psel_r;
  assign bus.conflict     = conflict_r;
  assign bus.addr_err     = addr_err_r;
  assign bus.busy         = (state_r == CLEAR);
  assign bus.clear_active = (state_r == CLEAR);
endmodule

// File: doc/regfile_write_decoder.md
Name: regfile_write_decoder

Overview:
Parametrised, registered write-enable decoder for the multi-port register file; successor to the single-port 5:32 combinational decoder. Converts NUM_PORTS write addresses/enables into one-hot per-register write strobes plus a per-register winning-port select. Resolves same-register conflicts and flags out-of-range addresses. Includes a sequential bulk-clear engine that strobes every writable register once while the datapath forces zero data.

Parameters:
ADDR_W, 5, write address width per port
NUM_REGS, 32, number of registers; legal range 2..2**ADDR_W
NUM_PORTS, 2, number of write ports; 1..4
ZERO_REG_RO, 1, 1 = register 0 is hardwired zero and never strobed (writes and clear)
PSEL_W, derived = max(1, clog2(NUM_PORTS)), width of the port-select field

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_en  in  NUM_PORTS  per-port write request (port p = bit p)
wr_addr  in  NUM_PORTS*ADDR_W  per-port address, port p = bits [p*ADDR_W +: ADDR_W]
clear_req  in  1  single-cycle pulse; starts bulk clear
we  out  NUM_REGS  registered one-hot-or-zero write strobes
port_sel  out  NUM_REGS*PSEL_W  winning port for register r, bits [r*PSEL_W +: PSEL_W]
clear_active  out  1  high during clear; datapath muxes write data to 0
busy  out  1  clear in progress; wr_en is ignored while high
conflict  out  1  registered pulse: two or more enabled ports hit the same legal register
addr_err  out  1  registered pulse: an enabled port addressed >= NUM_REGS

Behaviour:
- Reset (async assert, sync release): we=0, port_sel=0, clear_active=0, busy=0, conflict=0, addr_err=0, FSM=IDLE, clear counter=0.
- Latency: all outputs are registered; inputs sampled on edge N appear on outputs after edge N (1 cycle).
- Normal write (IDLE): for each legal register r, we[r]=1 if any enabled port addresses r. port_sel[r] = highest-index enabled port addressing r (the later instruction wins). port_sel[r] = 0 when we[r]=0.
- ZERO_REG_RO=1: address 0 is legal but never sets we[0]; it raises no conflict and no addr_err.
- Out-of-range (addr >= NUM_REGS): that port is dropped; addr_err=1 for one cycle; other ports are unaffected.
- conflict=1 for one cycle when >= 2 enabled ports target the same strobe-eligible register; the strobe still fires once, with priority applied.
- Multiple distinct addresses in the same cycle produce multiple we bits; we is one-hot per register, not globally one-hot.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req; the counter loads the first writable index (1 if ZERO_REG_RO, else 0). wr_en in that same cycle is ignored.
  - CLEAR: each cycle asserts we[cnt]=1 only, port_sel=0, clear_active=1, busy=1, and increments cnt. After strobing NUM_REGS-1, return to IDLE; busy/clear_active drop the cycle after the last strobe.
  - Clear takes NUM_REGS-ZERO_REG_RO cycles. clear_req while in CLEAR is ignored (no restart). wr_en in CLEAR is dropped with no conflict and no addr_err.
- Reset mid-clear: aborts immediately to the reset values; partial clear is not resumed.
- Combinational outputs (busy, clear_active) are derived from registered state only, with no input-to-output paths.

Test Plan:
- Reset with wr_en=2'b11 and addr {5,9} -> all outputs 0 while reset is high; after release and one edge, we=(1<<5)|(1<<9), port_sel[5]=0, port_sel[9]=1.
- Port0 addr 7, port1 addr 7, both enabled -> next cycle we=1<<7, port_sel[7]=1, conflict=1 for exactly one cycle.
- ZERO_REG_RO=1, port0 writes addr 0 -> we=0, conflict=0, addr_err=0; with ZERO_REG_RO=0 -> we=1.
- NUM_REGS=24, ADDR_W=5, port1 addr 30, port0 addr 3 -> we=1<<3, addr_err=1, port_sel[3]=0.
- clear_req pulse (NUM_REGS=32, ZERO_REG_RO=1) with wr_en=1 to addr 4 during clear -> we walks 1<<1..1<<31 over 31 consecutive cycles; busy is high for exactly 31 cycles; addr 4 gets no extra strobe; a second clear_req mid-walk does not restart it.
- Assert reset at clear step 10 -> outputs go 0 asynchronously; after release, a normal write to addr 2 gives we=1<<2 one cycle later.
